barcode_mimic_q: RTL and testbench

Parametrised, queued successor to the bench barcode transmitter. It accepts station IDs into an internal FIFO and serialises each one onto the single-wire BC line. Frames are pulse-width encoded: start, data MSB first, optional even parity, then a programmable inter-frame gap. It is used in top-level Follower benches to script multi-station routes without per-frame handshaking from the stimulus.

---
 rtl/barcode_pkg.sv | 16 +
 rtl/barcode_mimic_q_fifo.sv | 46 ++++
 rtl/barcode_mimic_q.sv | 139 +++++++++++++
 tb/tb_barcode_mimic_q.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/barcode_pkg.sv
// Shared state type, constants and pulse-width helpers for the queued barcode transmitter.
package barcode_pkg;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, GAP} bc_state_t;

    localparam int unsigned MIN_PERIOD = 4;

    function automatic logic [31:0] low_time_one(input logic [31:0] p);
        return p >> 2;
    endfunction

    function automatic logic [31:0] low_time_zero(input logic [31:0] p);
        return p - (p >> 2);
    endfunction

endpackage

// File: rtl/barcode_mimic_q_fifo.sv
// Synchronous FIFO with extra-MSB pointers; a write into a full FIFO succeeds
// when a read happens in the same cycle.
module bc_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr,
    input  logic             rd,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    input  logic             flush
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]      wptr_q, rptr_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_wr, do_rd;

    assign empty = (wptr_q == rptr_q);
    assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign dout  = mem_q[rptr_q[AW-1:0]];
    assign do_wr = wr && (!full || rd);
    assign do_rd = rd && !empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else if (flush) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (do_wr) wptr_q <= wptr_q + 1'b1;
            if (do_rd) rptr_q <= rptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr && !flush) mem_q[wptr_q[AW-1:0]] <= din;
    end

endmodule

// File: rtl/barcode_mimic_q.sv
// Queued single-wire barcode transmitter: pulse-width encoded start, data MSB first,
// optional even parity and an idle-high gap per queued station ID.
module barcode_mimic_q
    import barcode_pkg::*;
#(
    parameter int unsigned ID_W        = 8,
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned PERIOD_W    = 22,
    parameter int unsigned PARITY_EN   = 0,
    parameter int unsigned GAP_PERIODS = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [PERIOD_W-1:0] period,
    input  logic                send,
    input  logic [ID_W-1:0]     station_ID,
    input  logic                abort,
    input  logic                clr_ovf,
    output logic                BC,
    output logic                BC_done,
    output logic                busy,
    output logic                full,
    output logic                empty,
    output logic                ovf
);
    localparam int unsigned CNT_W = PERIOD_W + $clog2(GAP_PERIODS + 1);
    localparam int unsigned BIT_W = $clog2(ID_W + 1);

    bc_state_t           state_q, state_d;
    logic [PERIOD_W-1:0] p_q, pe;
    logic [CNT_W-1:0]    cnt_q, gap_last_q, p_ext, low_len;
    logic [BIT_W-1:0]    bit_q;
    logic [ID_W-1:0]     shift_q, head;
    logic                par_q, bc_q, bc_d, ovf_q;
    logic                pop, wr, period_end, gap_end, bit_last, cur_bit;

    assign pop = (state_q == IDLE) && !empty && !abort;
    assign wr  = send && !abort && (!full || pop);

    bc_fifo #(
        .WIDTH(ID_W),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk  (clk),
        .rst_n(rst_n),
        .wr   (wr),
        .rd   (pop),
        .din  (station_ID),
        .dout (head),
        .full (full),
        .empty(empty),
        .flush(abort)
    );

    assign pe         = (period < PERIOD_W'(MIN_PERIOD)) ? PERIOD_W'(MIN_PERIOD) : period;
    assign p_ext      = CNT_W'(p_q);
    assign period_end = (cnt_q == p_ext - 1'b1);
    assign gap_end    = (cnt_q == gap_last_q);
    assign bit_last   = (bit_q == BIT_W'(ID_W - 1));
    assign cur_bit    = (state_q == PARITY) ? par_q : shift_q[ID_W-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (pop) state_d = START;
            START:   if (period_end) state_d = DATA;
            DATA:    if (period_end && bit_last) state_d = (PARITY_EN != 0) ? PARITY : GAP;
            PARITY:  if (period_end) state_d = GAP;
            GAP:     if (gap_end) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (abort) state_d = IDLE;
    end

    // Low time of the current symbol; IDLE and GAP keep it zero so the line stays high.
    always_comb begin
        low_len = '0;
        unique case (state_q)
            START:        low_len = p_ext >> 1;
            DATA, PARITY: low_len = cur_bit ? CNT_W'(low_time_one(32'(p_q)))
                                            : CNT_W'(low_time_zero(32'(p_q)));
            default:      low_len = '0;
        endcase
        bc_d    = !((cnt_q < low_len) && !abort);
        BC_done = (state_q == GAP) && gap_end && !abort;
        busy    = (state_q != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_q        <= PERIOD_W'(MIN_PERIOD);
            cnt_q      <= '0;
            gap_last_q <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            par_q      <= 1'b0;
        end else if (abort) begin
            cnt_q <= '0;
            bit_q <= '0;
        end else if (pop) begin
            p_q     <= pe;
            shift_q <= head;
            par_q   <= ^head;
            cnt_q   <= '0;
            bit_q   <= '0;
        end else if (state_q != IDLE) begin
            if ((state_q == GAP) ? gap_end : period_end) cnt_q <= '0;
            else                                         cnt_q <= cnt_q + 1'b1;
            if (state_q == DATA && period_end) begin
                shift_q <= shift_q << 1;
                bit_q   <= bit_q + 1'b1;
            end
            // Gap length is formed once on entry so the multiply is off the per-cycle path.
            if (state_d == GAP && state_q != GAP) begin
                gap_last_q <= CNT_W'(GAP_PERIODS) * p_ext - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bc_q  <= 1'b1;
            ovf_q <= 1'b0;
        end else begin
            bc_q <= bc_d;
            if (send && full && !pop && !abort) ovf_q <= 1'b1;
            else if (clr_ovf)                   ovf_q <= 1'b0;
        end
    end

    assign BC  = bc_q;
    assign ovf = ovf_q;

endmodule

// File: tb/tb_barcode_mimic_q.sv
// Scoreboard bench: two transmitters (parity off / on) share stimulus; expected pulse
// widths and frame lengths are queued at send time and checked by a negedge monitor.
module tb_barcode_mimic_q;
    localparam int GAP = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [21:0] period;
    logic        send, abort, clr_ovf;
    logic [7:0]  station_id;
    logic [1:0]  bc_v, done_v, busy_v, full_v, empty_v, ovf_v;

    int checks = 0;
    int errors = 0;
    bit mon_en = 1'b0;

    int exp_low  [2][$];
    int exp_high [2][$];
    int exp_len  [2][$];
    int exp_cnt  [2][$];

    always #5 clk = ~clk;

    barcode_mimic_q #(
        .ID_W(8), .FIFO_DEPTH(4), .PERIOD_W(22), .PARITY_EN(0), .GAP_PERIODS(GAP)
    ) dut0 (
        .clk(clk), .rst_n(rst_n), .period(period), .send(send), .station_ID(station_id),
        .abort(abort), .clr_ovf(clr_ovf), .BC(bc_v[0]), .BC_done(done_v[0]),
        .busy(busy_v[0]), .full(full_v[0]), .empty(empty_v[0]), .ovf(ovf_v[0])
    );

    barcode_mimic_q #(
        .ID_W(8), .FIFO_DEPTH(4), .PERIOD_W(22), .PARITY_EN(1), .GAP_PERIODS(GAP)
    ) dut1 (
        .clk(clk), .rst_n(rst_n), .period(period), .send(send), .station_ID(station_id),
        .abort(abort), .clr_ovf(clr_ovf), .BC(bc_v[1]), .BC_done(done_v[1]),
        .busy(busy_v[1]), .full(full_v[1]), .empty(empty_v[1]), .ovf(ovf_v[1])
    );

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual %0d required %0d", name, act, req);
        end
    endtask

    // Reference frame: list of (low, high) symbol widths and total busy length.
    task automatic push_frame(input logic [7:0] id, input int per);
        int p, lo, n;
        p = (per < 4) ? 4 : per;
        for (int i = 0; i < 2; i++) begin
            n = 1;
            exp_low[i].push_back(p / 2);
            exp_high[i].push_back(p - p / 2);
            for (int b = 7; b >= 0; b--) begin
                lo = id[b] ? p / 4 : p - p / 4;
                exp_low[i].push_back(lo);
                exp_high[i].push_back(p - lo);
                n++;
            end
            if (i == 1) begin
                lo = (^id) ? p / 4 : p - p / 4;
                exp_low[i].push_back(lo);
                exp_high[i].push_back(p - lo);
                n++;
            end
            exp_high[i][exp_high[i].size() - 1] = 0;  // last symbol runs into the gap
            exp_len[i].push_back(p * (n + GAP));
            exp_cnt[i].push_back(n);
        end
    endtask

    task automatic flush_model();
        for (int i = 0; i < 2; i++) begin
            exp_low[i].delete();
            exp_high[i].delete();
            exp_len[i].delete();
            exp_cnt[i].delete();
        end
    endtask

    int  low_run[2], high_run[2], pend_high[2], pulses[2], busy_run[2], done_cnt[2];
    logic last_done[2];

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!mon_en) begin
                low_run[i] = 0; high_run[i] = 0; pend_high[i] = 0; pulses[i] = 0;
                busy_run[i] = 0; done_cnt[i] = 0; last_done[i] = 1'b0;
            end else begin
                if (bc_v[i] == 1'b0) begin
                    if (low_run[i] == 0 && pend_high[i] != 0)
                        chk($sformatf("high_width dut%0d", i), high_run[i], pend_high[i]);
                    low_run[i]++;
                end else if (low_run[i] != 0) begin
                    if (exp_low[i].size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL extra_pulse dut%0d actual width %0d required none",
                                 i, low_run[i]);
                        pend_high[i] = 0;
                    end else begin
                        chk($sformatf("low_width dut%0d", i), low_run[i], exp_low[i].pop_front());
                        pend_high[i] = exp_high[i].pop_front();
                    end
                    pulses[i]++;
                    low_run[i] = 0;
                    high_run[i] = 1;
                end else begin
                    high_run[i]++;
                end

                if (done_v[i]) done_cnt[i]++;
                if (busy_v[i]) begin
                    busy_run[i]++;
                end else if (busy_run[i] != 0) begin
                    if (exp_len[i].size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL extra_frame dut%0d actual len %0d required none",
                                 i, busy_run[i]);
                    end else begin
                        chk($sformatf("frame_len dut%0d", i), busy_run[i], exp_len[i].pop_front());
                        chk($sformatf("symbols dut%0d", i), pulses[i], exp_cnt[i].pop_front());
                    end
                    chk($sformatf("done_on_last dut%0d", i), int'(last_done[i]), 1);
                    chk($sformatf("done_count dut%0d", i), done_cnt[i], 1);
                    busy_run[i] = 0;
                    pulses[i] = 0;
                    done_cnt[i] = 0;
                end
                last_done[i] = done_v[i];
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_id(input logic [7:0] id, input bit accepted);
        if (accepted) push_frame(id, int'(period));
        station_id = id;
        send = 1'b1;
        tick();
        send = 1'b0;
    endtask

    task automatic wait_drained(input string name, input int budget);
        int c;
        c = 0;
        while (!(busy_v == 2'b00 && empty_v == 2'b11 && exp_len[0].size() == 0 &&
                 exp_len[1].size() == 0) && c < budget) begin
            tick();
            c++;
        end
        chk(name, int'(c < budget), 1);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog actual timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, c, nd, nb;
        period = 22'd32; send = 1'b0; abort = 1'b0; clr_ovf = 1'b0; station_id = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_bc", int'(bc_v), 3);
        chk("rst_done", int'(done_v), 0);
        chk("rst_busy", int'(busy_v), 0);
        chk("rst_full", int'(full_v), 0);
        chk("rst_empty", int'(empty_v), 3);
        chk("rst_ovf", int'(ovf_v), 0);
        rst_n = 1'b1;
        tick();
        mon_en = 1'b1;

        period = 22'd32;
        send_id(8'hA5, 1'b1);
        wait_drained("drain_a5", 4000);

        send_id(8'h07, 1'b1);
        send_id(8'h03, 1'b1);
        wait_drained("drain_parity", 4000);

        period = 22'd2;
        send_id(8'h6C, 1'b1);
        wait_drained("drain_min_period", 4000);

        // The first ID pops the edge after it is written, so five fit before the FIFO is full.
        period = 22'd4;
        for (int k = 1; k <= 5; k++) send_id(8'(k), 1'b1);
        chk("full_after_five", int'(full_v), 3);
        chk("ovf_before", int'(ovf_v), 0);
        send_id(8'h06, 1'b0);
        chk("ovf_set", int'(ovf_v), 3);
        clr_ovf = 1'b1;
        send_id(8'h07, 1'b0);
        chk("ovf_set_wins", int'(ovf_v), 3);
        tick();
        clr_ovf = 1'b0;
        chk("ovf_clr", int'(ovf_v), 0);
        wait_drained("drain_ovf", 4000);

        for (int it = 0; it < 12; it++) begin
            period = 22'($urandom_range(0, 24));
            n = int'($urandom_range(1, 4));
            for (int k = 0; k < n; k++) begin
                send_id(8'($urandom), 1'b1);
                repeat ($urandom_range(0, 2)) tick();
            end
            c = 0;
            while (empty_v != 2'b11 && c < 2000) begin
                tick();
                c++;
            end
            chk("rnd_empty", int'(c < 2000), 1);
            // Once the last ID has been popped, the period input must no longer matter.
            while (busy_v != 2'b00 && c < 6000) begin
                period = 22'($urandom);
                tick();
                c++;
            end
            wait_drained("drain_rnd", 6000);
        end

        mon_en = 1'b0;
        flush_model();
        period = 22'd8;
        send_id(8'h11, 1'b0);
        send_id(8'h22, 1'b0);
        send_id(8'h33, 1'b0);
        repeat (12) tick();
        chk("abort_pre_busy", int'(busy_v), 3);
        abort = 1'b1;
        send = 1'b1;
        station_id = 8'h55;
        tick();
        abort = 1'b0;
        send = 1'b0;
        chk("abort_bc", int'(bc_v), 3);
        chk("abort_empty", int'(empty_v), 3);
        chk("abort_busy", int'(busy_v), 0);
        chk("abort_ovf", int'(ovf_v), 0);
        nd = 0;
        nb = 0;
        for (int k = 0; k < 80; k++) begin
            if (done_v != 2'b00) nd++;
            if (busy_v != 2'b00) nb++;
            tick();
        end
        chk("abort_no_done", nd, 0);
        chk("abort_no_frame", nb, 0);

        send_id(8'h33, 1'b0);
        repeat (20) tick();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_bc", int'(bc_v), 3);
        chk("arst_busy", int'(busy_v), 0);
        chk("arst_empty", int'(empty_v), 3);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
        mon_en = 1'b1;
        send_id(8'h02, 1'b1);
        tick();
        chk("latency_n1", int'(bc_v), 3);
        tick();
        chk("latency_n2", int'(bc_v), 0);
        wait_drained("drain_after_reset", 4000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
